// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its output FIFO.
package fetch_pkg;

  localparam int          FETCH_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  // The FIFO default entry type; the top re-declares it at its own WIDTH.
  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [31:0]            instr;
    logic                   misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO between fetch and decode; the head is read straight from
// registered storage, so it holds still while it waits to be popped. Flush wins over push/pop.
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        data_i,
  output entry_t        data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   count_o
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, PC tagging, redirect squash.
// Optional misaligned-PC detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage import fetch_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             redirect_i,
  output logic             pc_stall_o,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             if_valid_o,
  input  logic             if_ready_i,
  output logic [WIDTH-1:0] if_pc_o,
  output logic [31:0]      if_instr_o,
  output logic             if_misaligned_o
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [31:0]      instr;
    logic             misaligned;
  } entry_t;

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             push, pop, full, empty;
  logic [PW:0]      count, count_after;
  logic             space_after;
  logic             misalign_req, misalign_hold;
  entry_t           push_entry, head;

  assign pop         = !empty && if_ready_i;
  assign count_after = count + (PW+1)'(1) - (PW+1)'(pop);
  assign space_after = (count_after < DEPTH_CNT);

  assign imem_addr_o = {pc_i[WIDTH-1:2], 2'b00};
  assign pc_stall_o  = !(imem_req_o && imem_gnt_i);

  // Every path into S_REQ leaves room in the FIFO, so "not full" is the whole
  // occupancy-plus-outstanding test there.
  always_comb begin
    state_d               = state_q;
    req_pc_d              = req_pc_q;
    imem_req_o            = 1'b0;
    push                  = 1'b0;
    push_entry.pc         = req_pc_q;
    push_entry.instr      = imem_rdata_i;
    push_entry.misaligned = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_i || (pop && !misalign_hold)) state_d = S_REQ;
      end
      S_REQ: begin
        if (!full) begin
          if (misalign_req) begin
            if (!redirect_i) begin
              push                  = 1'b1;
              push_entry.pc         = pc_i;
              push_entry.instr      = NOP_INSTR;
              push_entry.misaligned = 1'b1;
              state_d               = S_IDLE;
            end
          end else begin
            imem_req_o = 1'b1;
            if (imem_gnt_i) begin
              req_pc_d = pc_i;
              state_d  = redirect_i ? S_DROP : S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            state_d = S_REQ;
          end else begin
            push    = 1'b1;
            state_d = space_after ? S_REQ : S_IDLE;
          end
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (push_entry),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign if_valid_o = !empty;
  assign if_pc_o    = head.pc;
  assign if_instr_o = head.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  // After a misaligned marker the stage parks in S_IDLE until the PC is redirected.
  logic hold_q, hold_d;

  assign misalign_req = (pc_i[1:0] != 2'b00);

  always_comb begin
    hold_d = hold_q;
    if (redirect_i)                                  hold_d = 1'b0;
    else if (state_q == S_REQ && !full && misalign_req) hold_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= 1'b0;
    else     hold_q <= hold_d;
  end

  assign misalign_hold   = hold_q;
  assign if_misaligned_o = head.misaligned;
`else
  logic unused_misaligned;

  assign misalign_req      = 1'b0;
  assign misalign_hold     = 1'b0;
  assign if_misaligned_o   = 1'b0;
  assign unused_misaligned = head.misaligned;
`endif

endmodule
